// File: rtl/led_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer, its pixel memory and the LED serializer.
// The master modport is the sequencer's view; slave is the environment's view.
interface led_frame_sequencer_if;
  logic        start;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [23:0] rd_data;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        ser_busy;
  logic        busy;
  logic        frame_done;

  modport master (
    input  start, rd_data, pix_ready, ser_busy,
    output rd_en, rd_addr, pix_valid, pix_data, busy, frame_done
  );

  modport slave (
    output start, rd_data, pix_ready, ser_busy,
    input  rd_en, rd_addr, pix_valid, pix_data, busy, frame_done
  );
endinterface

// File: rtl/led_frame_sequencer.sv
// Walks every pixel of every face, fetching each colour from memory and handing it to
// the serializer, then holds the line idle long enough for the LEDs to latch the frame.
module led_frame_sequencer #(
  parameter int NUM_FACES    = 6,
  parameter int PIX_PER_FACE = 64,
  parameter int LATCH_CYCLES = 2000
) (
  input logic            clk,
  input logic            rst,
  led_frame_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_LATCH,
    S_DONE
  } state_t;

  localparam logic [2:0]  LAST_FACE  = 3'(NUM_FACES - 1);
  localparam logic [5:0]  LAST_PIX   = 6'(PIX_PER_FACE - 1);
  localparam logic [11:0] LATCH_LAST = 12'(LATCH_CYCLES - 1);

  state_t      state_q;
  logic [2:0]  face_q;
  logic [5:0]  pixel_q;
  logic [11:0] latch_cnt_q;
  logic        pending_q;
  logic [23:0] pix_data_q;
  logic        pix_valid_q;
  logic        rd_en_q;
  logic [8:0]  rd_addr_q;
  logic        busy_q;
  logic        frame_done_q;

  logic [2:0]  face_d;
  logic [5:0]  pixel_d;
  logic        last_pix;

  always_comb begin
    face_d   = face_q;
    pixel_d  = pixel_q + 6'd1;
    last_pix = (face_q == LAST_FACE) && (pixel_q == LAST_PIX);
    if (pixel_q == LAST_PIX) begin
      pixel_d = 6'd0;
      face_d  = face_q + 3'd1;
    end
  end

  // Outputs are registered, so each one is set on the transition into the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      face_q       <= 3'd0;
      pixel_q      <= 6'd0;
      latch_cnt_q  <= 12'd0;
      pending_q    <= 1'b0;
      pix_data_q   <= 24'd0;
      pix_valid_q  <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= 9'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.start && busy_q) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.start || pending_q) begin
            face_q    <= 3'd0;
            pixel_q   <= 6'd0;
            pending_q <= 1'b0;
            rd_addr_q <= 9'd0;
            rd_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          pix_data_q  <= bus.rd_data;
          pix_valid_q <= 1'b1;
          state_q     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (bus.pix_ready) begin
            pix_valid_q <= 1'b0;
            if (last_pix) begin
              latch_cnt_q <= 12'd0;
              state_q     <= S_LATCH;
            end else begin
              face_q    <= face_d;
              pixel_q   <= pixel_d;
              rd_addr_q <= {face_d, pixel_d};
              rd_en_q   <= 1'b1;
              state_q   <= S_FETCH;
            end
          end
        end
        S_LATCH: begin
          // Any serializer activity restarts the idle-line measurement.
          if (bus.ser_busy) begin
            latch_cnt_q <= 12'd0;
          end else if (latch_cnt_q == LATCH_LAST) begin
            frame_done_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            latch_cnt_q <= latch_cnt_q + 12'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer with a small 2x4 frame; memory returns the address as data
// and a scoreboard holds the expected fetch addresses and transferred pixels.
module tb_led_frame_sequencer;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  led_frame_sequencer_if bus();

  led_frame_sequencer #(
    .NUM_FACES   (2),
    .PIX_PER_FACE(4),
    .LATCH_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= {15'd0, bus.rd_addr};
  end

  logic [8:0]  exp_addr_q[$];
  logic [23:0] exp_pix_q[$];
  int          xfer_times[$];
  int          done_times[$];
  int          fetch0_times[$];

  // Scoreboard monitor: every fetch and every transfer must match the next expected entry.
  always @(negedge clk) begin
    logic [8:0]  ea;
    logic [23:0] ep;
    if (!rst) begin
      if (bus.rd_en) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL rd_addr_unexpected got=%0d required=none cyc=%0d", bus.rd_addr, cyc);
        end else begin
          ea = exp_addr_q.pop_front();
          if (bus.rd_addr !== ea) begin
            failures++;
            $display("FAIL rd_addr got=%0d required=%0d cyc=%0d", bus.rd_addr, ea, cyc);
          end
        end
        if (bus.rd_addr == 9'd0) fetch0_times.push_back(cyc);
      end
      if (bus.pix_valid && bus.pix_ready) begin
        checks++;
        if (exp_pix_q.size() == 0) begin
          failures++;
          $display("FAIL pix_unexpected got=%0d required=none cyc=%0d", bus.pix_data, cyc);
        end else begin
          ep = exp_pix_q.pop_front();
          if (bus.pix_data !== ep) begin
            failures++;
            $display("FAIL pix_data got=%0d required=%0d cyc=%0d", bus.pix_data, ep, cyc);
          end
        end
        xfer_times.push_back(cyc);
      end
      if (bus.frame_done) done_times.push_back(cyc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 4; p++) begin
        exp_addr_q.push_back(9'(f * 64 + p));
        exp_pix_q.push_back(24'(f * 64 + p));
      end
    end
  endtask

  task automatic clear_logs;
    xfer_times.delete();
    done_times.delete();
    fetch0_times.delete();
  endtask

  task automatic pulse_start(output int s_cyc);
    tick();
    bus.start = 1'b1;
    s_cyc = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_times.size() >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.pix_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=busy%b rd_en%b pv%b fd%b required=0000", bus.busy, bus.rd_en, bus.pix_valid, bus.frame_done);
    end
    checks++;
    if (bus.pix_data !== 24'd0 || bus.rd_addr !== 9'd0) begin
      failures++;
      $display("FAIL reset_data got=pix%0d addr%0d required=0", bus.pix_data, bus.rd_addr);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=busy%b rd_en%b required=00", bus.busy, bus.rd_en);
    end
  endtask

  task automatic test_basic_frame;
    int s_cyc;
    bit ok;
    clear_logs();
    bus.pix_ready = 1'b1;
    bus.ser_busy  = 1'b0;
    push_frame();
    pulse_start(s_cyc);
    wait_done(1, 200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_done_timeout got=0 required=1");
    end
    checks++;
    if (fetch0_times.size() < 1 || fetch0_times[0] != s_cyc + 1) begin
      failures++;
      $display("FAIL basic_first_fetch got=%0d required=%0d", fetch0_times.size() > 0 ? fetch0_times[0] : -1, s_cyc + 1);
    end
    checks++;
    if (xfer_times.size() != 8) begin
      failures++;
      $display("FAIL basic_xfer_count got=%0d required=8", xfer_times.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (xfer_times[i] - xfer_times[i-1] != 3) begin
          failures++;
          $display("FAIL basic_xfer_gap idx=%0d got=%0d required=3", i, xfer_times[i] - xfer_times[i-1]);
        end
      end
      checks++;
      if (done_times.size() < 1 || done_times[0] - xfer_times[7] != 6) begin
        failures++;
        $display("FAIL basic_latch_time got=%0d required=6", done_times.size() > 0 ? done_times[0] - xfer_times[7] : -1);
      end
    end
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || done_times.size() != 1) begin
      failures++;
      $display("FAIL basic_after_done got=busy%b fd%b n%0d required=busy0 fd0 n1", bus.busy, bus.frame_done, done_times.size());
    end
  endtask

  task automatic test_stall;
    int s_cyc;
    int stall;
    bit ok;
    clear_logs();
    bus.pix_ready = 1'b1;
    push_frame();
    pulse_start(s_cyc);
    stall = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done_times.size() >= 1) begin
        ok = 1'b1;
        break;
      end
      if (stall == 0 && bus.pix_valid && bus.pix_data == 24'd2) begin
        bus.pix_ready = 1'b0;
        stall = 1;
      end else if (stall >= 1 && stall <= 10) begin
        checks++;
        if (bus.pix_valid !== 1'b1 || bus.pix_data !== 24'd2 || bus.rd_en !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got=pv%b pix%0d rd_en%b required=pv1 pix2 rd_en0", stall, bus.pix_valid, bus.pix_data, bus.rd_en);
        end
        if (stall == 10) bus.pix_ready = 1'b1;
        stall++;
      end
      tick();
    end
    checks++;
    if (!ok || stall != 11) begin
      failures++;
      $display("FAIL stall_progress got=done%b stall%0d required=done1 stall11", ok, stall);
    end
    checks++;
    if (xfer_times.size() != 8 || xfer_times[2] - xfer_times[1] != 13) begin
      failures++;
      $display("FAIL stall_gap got=%0d required=13", xfer_times.size() > 2 ? xfer_times[2] - xfer_times[1] : -1);
    end
  endtask

  task automatic test_latch_busy;
    int s_cyc;
    int lat_rel;
    bit [5:0] pat;
    bit ok;
    clear_logs();
    pat = 6'b100111;
    bus.pix_ready = 1'b1;
    bus.ser_busy  = 1'b0;
    push_frame();
    pulse_start(s_cyc);
    lat_rel = -1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done_times.size() >= 1) begin
        ok = 1'b1;
        break;
      end
      if (lat_rel >= 0) begin
        bus.ser_busy = (lat_rel < 6) ? pat[lat_rel] : 1'b0;
        lat_rel++;
      end
      if (lat_rel < 0 && bus.pix_valid && bus.pix_data == 24'd67) lat_rel = 0;
      tick();
    end
    bus.ser_busy = 1'b0;
    checks++;
    if (!ok || xfer_times.size() != 8) begin
      failures++;
      $display("FAIL latch_run got=done%b xfers%0d required=done1 xfers8", ok, xfer_times.size());
    end else begin
      checks++;
      if (done_times[0] - xfer_times[7] != 12) begin
        failures++;
        $display("FAIL latch_restart got=%0d required=12", done_times[0] - xfer_times[7]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int s_cyc;
    bit s2;
    bit s3;
    bit p_seen;
    bit ok;
    clear_logs();
    bus.pix_ready = 1'b1;
    bus.ser_busy  = 1'b0;
    push_frame();
    pulse_start(s_cyc);
    s2 = 1'b0;
    s3 = 1'b0;
    p_seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_times.size() >= 2) begin
        ok = 1'b1;
        break;
      end
      bus.start = 1'b0;
      if (!s2 && bus.pix_valid) begin
        bus.start = 1'b1;
        push_frame();
        s2 = 1'b1;
      end else if (p_seen && !s3) begin
        bus.start = 1'b1;
        s3 = 1'b1;
      end
      if (!p_seen && bus.pix_valid && bus.pix_data == 24'd67) p_seen = 1'b1;
      tick();
    end
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (!ok || done_times.size() != 2) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d required=2", done_times.size());
    end
    checks++;
    if (fetch0_times.size() != 2 || done_times.size() < 1 || fetch0_times[1] != done_times[0] + 2) begin
      failures++;
      $display("FAIL b2b_restart got=%0d required=%0d", fetch0_times.size() > 1 ? fetch0_times[1] : -1, done_times.size() > 0 ? done_times[0] + 2 : -1);
    end
    checks++;
    if (exp_addr_q.size() != 0 || exp_pix_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_leftover got=%0d/%0d required=0/0", exp_addr_q.size(), exp_pix_q.size());
    end
  endtask

  task automatic test_async_reset;
    int s_cyc;
    int n_before;
    bit found;
    bit ok;
    clear_logs();
    bus.pix_ready = 1'b1;
    push_frame();
    pulse_start(s_cyc);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.pix_valid && bus.pix_data == 24'd65) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL areset_reach got=0 required=1");
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pix_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate got=pv%b busy%b rd_en%b required=000", bus.pix_valid, bus.busy, bus.rd_en);
    end
    exp_addr_q.delete();
    exp_pix_q.delete();
    n_before = done_times.size();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (done_times.size() != n_before || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL areset_no_done got=n%0d busy%b required=n%0d busy0", done_times.size(), bus.busy, n_before);
    end
    push_frame();
    pulse_start(s_cyc);
    checks++;
    if (bus.rd_en !== 1'b1 || bus.rd_addr !== 9'd0) begin
      failures++;
      $display("FAIL areset_restart got=rd_en%b addr%0d required=rd_en1 addr0", bus.rd_en, bus.rd_addr);
    end
    wait_done(n_before + 1, 200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL areset_frame_timeout got=0 required=1");
    end
  endtask

  initial begin
    cyc           = 0;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.pix_ready = 1'b0;
    bus.ser_busy  = 1'b0;
    test_reset();
    test_basic_frame();
    test_stall();
    test_latch_busy();
    test_back_to_back();
    test_async_reset();
    tick();
    checks++;
    if (exp_addr_q.size() != 0 || exp_pix_q.size() != 0) begin
      failures++;
      $display("FAIL final_leftover got=%0d/%0d required=0/0", exp_addr_q.size(), exp_pix_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_frame_sequencer.md
LED_FRAME_SEQUENCER -- requirements
Module: led_frame_sequencer

Interface
REQ-001 Parameter NUM_FACES, default 6: faces per frame, range 1..8.
REQ-002 Parameter PIX_PER_FACE, default 64: LEDs per face, range 1..64.
REQ-003 Parameter LATCH_CYCLES, default 2000: line-idle cycles after the last pixel (50 us at 40 MHz), range 1..4095.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset  input  1  one clock; reset is asynchronous and active-high.
REQ-006 start  input  1  single-cycle request to transmit one full frame.
REQ-007 rd_en  output  1  pixel-memory read strobe.
REQ-008 rd_addr  output  9  pixel address = face*64 + pixel.
REQ-009 rd_data  input  24  pixel colour, valid exactly one cycle after rd_en.
REQ-010 pix_valid  output  1  pix_data holds a pixel for the serializer.
REQ-011 pix_data  output  24  registered colour presented to the serializer.
REQ-012 pix_ready  input  1  serializer accepts pix_data this cycle.
REQ-013 ser_busy  input  1  serializer is still driving a bit.
REQ-014 busy  output  1  high from frame acceptance until frame_done.
REQ-015 frame_done  output  1  single-cycle pulse at frame completion.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, WAIT, PRESENT, LATCH and DONE.
REQ-017 IDLE: on start or pending, clear face=0 and pixel=0, clear pending, go to FETCH; busy=0.
REQ-018 FETCH: rd_en=1 for exactly one cycle with rd_addr={face,pixel}; go to WAIT.
REQ-019 WAIT: capture rd_data into pix_data at the cycle end; go to PRESENT.
REQ-020 PRESENT: pix_valid=1 and pix_data held stable until the cycle in which pix_ready=1; a transfer occurs in that cycle.
REQ-021 On transfer, if the pixel is not the last of the frame, advance the address and go to FETCH.
REQ-022 Address advance: pixel increments; at PIX_PER_FACE-1 pixel wraps to 0 and face increments.
REQ-023 On transfer of the last pixel (face=NUM_FACES-1, pixel=PIX_PER_FACE-1), go to LATCH with latch count=0.
REQ-024 pix_ready outside PRESENT SHALL be ignored.
REQ-025 LATCH: the count increments each cycle ser_busy=0 and clears to 0 in any cycle ser_busy=1.
REQ-026 LATCH exits to DONE in the cycle after the count reaches LATCH_CYCLES-1; the latch count is 12 bits.
REQ-027 DONE: frame_done=1 for one cycle; go to IDLE.
REQ-028 busy=1 in FETCH, WAIT, PRESENT, LATCH and DONE.
REQ-029 A start while busy=1, including the DONE cycle, SHALL set a one-deep pending flag; further starts while it is set are dropped.
REQ-030 The pending frame begins from IDLE on the cycle after DONE, so there is exactly one IDLE cycle between frames.
REQ-031 Maximum throughput is one pixel per 3 cycles (FETCH, WAIT, PRESENT with pix_ready=1).
REQ-032 rd_addr holds its last value outside FETCH; rd_en=0 outside FETCH.

Reset
REQ-033 reset=1 SHALL immediately, without waiting for clk, force state=IDLE.
REQ-034 reset=1 SHALL also clear face, pixel, latch count, pending and pix_data to 0, and drive rd_en=0, pix_valid=0, busy=0 and frame_done=0.
REQ-035 Reset mid-frame abandons the frame with no frame_done; the first start after deassertion begins at address 0.

Verification (bench parameters NUM_FACES=2, PIX_PER_FACE=4, LATCH_CYCLES=5; memory returns addr as data)
REQ-036 start with pix_ready tied high and ser_busy=0 -> rd_addr sequence 0,1,2,3,64,65,66,67; 8 transfers 3 cycles apart; frame_done 5 cycles after the last-pixel LATCH entry.
REQ-037 pix_ready held low 10 cycles in PRESENT for pixel 2 -> pix_valid high and pix_data=2 stable for all 10 cycles; no rd_en until the transfer.
REQ-038 ser_busy=1 for 3 cycles at LATCH entry, then 1 more cycle after 2 idle cycles -> count restarts at 0 each time; frame_done only after 5 consecutive idle cycles.
REQ-039 start pulsed in PRESENT and again in LATCH -> exactly one additional frame, starting 1 cycle after frame_done; 2 frame_done pulses total.
REQ-040 reset asserted asynchronously mid-PRESENT at pixel 65 -> pix_valid and busy fall before the next clk edge; no frame_done; the next start fetches address 0.
